// File: rtl/ap_prefix_builder_b8.sv
// ap_prefix_builder_b8
//   Upstream feeder of the code-8 low-entropy codebook lookup. Symbols (4-bit
//   nibbles) are shifted into an active prefix; the candidate prefix (current
//   prefix plus the offered symbol) is presented combinationally to an external
//   codebook. On a codebook match the codeword is registered for the bit packer
//   and the prefix is cleared. A flush request emits the residual prefix as a
//   flush beat.
//
// Optional feature: define AP_OVERFLOW_CHECK_EN to turn a prefix overflow into
//   a sticky err_o plus a flush beat carrying the overflowing prefix. Without it
//   an overflow silently clears the prefix and err_o is tied low.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   sym_valid_i/sym_i   input symbol handshake (4'hF = escape/terminator)
//   sym_ready_o         symbol accepted when sym_valid_i & sym_ready_o
//   flush_i             end-of-segment request (edge-qualified)
//   ap_cnt_o/ap_data_o  candidate prefix to codebook (newest nibble in [3:0])
//   cb_match_i, cb_length_i, cb_data_i   codebook response
//   cw_valid_o/cw_ready_i   1-deep output beat handshake
//   cw_flush_o          beat carries a residual prefix instead of a codeword
//   cw_length_o         codeword length or residual nibble count
//   cw_data_o           codeword (right-aligned) or residual prefix
//   err_o               sticky overflow flag
module ap_prefix_builder_b8 #(
  parameter int unsigned CODEBOOK_LENGTH_MAX = 64,
  parameter int unsigned ENCODE_DATALENGTH   = 21,
  parameter int unsigned MAX_PREFIX_LEN      = 12
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           sym_valid_i,
  input  logic [3:0]                     sym_i,
  output logic                           sym_ready_o,
  input  logic                           flush_i,
  output logic [5:0]                     ap_cnt_o,
  output logic [CODEBOOK_LENGTH_MAX-1:0] ap_data_o,
  input  logic                           cb_match_i,
  input  logic [5:0]                     cb_length_i,
  input  logic [ENCODE_DATALENGTH-1:0]   cb_data_i,
  output logic                           cw_valid_o,
  input  logic                           cw_ready_i,
  output logic                           cw_flush_o,
  output logic [5:0]                     cw_length_o,
  output logic [CODEBOOK_LENGTH_MAX-1:0] cw_data_o,
  output logic                           err_o
);

  localparam logic [5:0] MAX_LEN = 6'(MAX_PREFIX_LEN);

  typedef enum logic {
    ST_ACCUM,
    ST_FLUSH
  } state_t;

  state_t                           r_state;
  logic [5:0]                       r_ap_cnt;
  logic [CODEBOOK_LENGTH_MAX-1:0]   r_ap_data;
  logic                             r_cw_valid;
  logic                             r_cw_flush;
  logic [5:0]                       r_cw_length;
  logic [CODEBOOK_LENGTH_MAX-1:0]   r_cw_data;
  // Cleared when a flush is taken, re-armed once flush_i is seen low, so a
  // held flush_i yields a single flush.
  logic                             r_flush_armed;

  logic w_slot_free;
  logic w_sym_accept;
  logic w_flush_start;
  logic w_overflow;

  assign ap_cnt_o    = r_ap_cnt + 6'd1;
  assign ap_data_o   = {r_ap_data[CODEBOOK_LENGTH_MAX-5:0], sym_i};

  assign w_slot_free   = ~r_cw_valid | cw_ready_i;
  assign sym_ready_o   = (r_state == ST_ACCUM) & ~flush_i & w_slot_free;
  assign w_sym_accept  = sym_valid_i & sym_ready_o;
  assign w_flush_start = (r_state == ST_ACCUM) & flush_i & r_flush_armed;
  assign w_overflow    = ~cb_match_i & (ap_cnt_o >= MAX_LEN);

  assign cw_valid_o  = r_cw_valid;
  assign cw_flush_o  = r_cw_flush;
  assign cw_length_o = r_cw_length;
  assign cw_data_o   = r_cw_data;

`ifdef AP_OVERFLOW_CHECK_EN
  logic r_err;
  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= ST_ACCUM;
      r_ap_cnt      <= '0;
      r_ap_data     <= '0;
      r_cw_valid    <= 1'b0;
      r_cw_flush    <= 1'b0;
      r_cw_length   <= '0;
      r_cw_data     <= '0;
      r_flush_armed <= 1'b1;
`ifdef AP_OVERFLOW_CHECK_EN
      r_err         <= 1'b0;
`endif
    end else begin
      // Drain the output slot; a new beat loaded below overrides this, which
      // gives back-to-back beats without a bubble.
      if (cw_ready_i) begin
        r_cw_valid <= 1'b0;
      end
      if (!flush_i) begin
        r_flush_armed <= 1'b1;
      end

      case (r_state)
        ST_ACCUM: begin
          if (w_flush_start) begin
            r_state       <= ST_FLUSH;
            r_flush_armed <= 1'b0;
          end else if (w_sym_accept) begin
            if (cb_match_i) begin
              r_cw_valid  <= 1'b1;
              r_cw_flush  <= 1'b0;
              r_cw_length <= cb_length_i;
              r_cw_data   <= {{(CODEBOOK_LENGTH_MAX-ENCODE_DATALENGTH){1'b0}}, cb_data_i};
              r_ap_cnt    <= '0;
              r_ap_data   <= '0;
            end else if (w_overflow) begin
`ifdef AP_OVERFLOW_CHECK_EN
              r_err       <= 1'b1;
              r_cw_valid  <= 1'b1;
              r_cw_flush  <= 1'b1;
              r_cw_length <= MAX_LEN;
              r_cw_data   <= ap_data_o;
`endif
              r_ap_cnt    <= '0;
              r_ap_data   <= '0;
            end else begin
              r_ap_cnt    <= ap_cnt_o;
              r_ap_data   <= ap_data_o;
            end
          end
        end

        ST_FLUSH: begin
          if (w_slot_free) begin
            if (r_ap_cnt != '0) begin
              r_cw_valid  <= 1'b1;
              r_cw_flush  <= 1'b1;
              r_cw_length <= r_ap_cnt;
              r_cw_data   <= r_ap_data;
            end
            r_ap_cnt  <= '0;
            r_ap_data <= '0;
            r_state   <= ST_ACCUM;
          end
        end

        default: r_state <= ST_ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_ap_prefix_builder_b8.sv
module tb_ap_prefix_builder_b8;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        sym_valid_i = 1'b0;
  logic [3:0]  sym_i = 4'h0;
  logic        sym_ready_o;
  logic        flush_i = 1'b0;
  logic [5:0]  ap_cnt_o;
  logic [63:0] ap_data_o;
  logic        cb_match_i;
  logic [5:0]  cb_length_i;
  logic [20:0] cb_data_i;
  logic        cw_valid_o;
  logic        cw_ready_i = 1'b1;
  logic        cw_flush_o;
  logic [5:0]  cw_length_o;
  logic [63:0] cw_data_o;
  logic        err_o;

`ifdef AP_OVERFLOW_CHECK_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  ap_prefix_builder_b8 #(
    .CODEBOOK_LENGTH_MAX(64),
    .ENCODE_DATALENGTH(21),
    .MAX_PREFIX_LEN(12)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .sym_valid_i(sym_valid_i), .sym_i(sym_i), .sym_ready_o(sym_ready_o),
    .flush_i(flush_i),
    .ap_cnt_o(ap_cnt_o), .ap_data_o(ap_data_o),
    .cb_match_i(cb_match_i), .cb_length_i(cb_length_i), .cb_data_i(cb_data_i),
    .cw_valid_o(cw_valid_o), .cw_ready_i(cw_ready_i), .cw_flush_o(cw_flush_o),
    .cw_length_o(cw_length_o), .cw_data_o(cw_data_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // Emulated codebook: only prefixes ending in the escape nibble match. A few
  // fixed entries reproduce the reference vectors; the rest are arbitrary.
  function automatic logic [27:0] cb_lookup(input logic [5:0] cnt, input logic [63:0] d);
    logic [5:0]  len;
    logic [20:0] mask;
    logic [20:0] cw;
    if (d[3:0] != 4'hF) return '0;
    if (cnt == 6'd1)                     return {1'b1, 6'd9,  21'h0001EC};
    if (cnt == 6'd2  && d == 64'h1F)     return {1'b1, 6'd12, 21'h000FF8};
    if (cnt == 6'd3  && d == 64'h21F)    return {1'b1, 6'd16, 21'h00FFFE};
    if (cnt == 6'd10 && d == 64'hF)      return {1'b1, 6'd12, 21'h000FFB};
    len  = 6'(2 + ((32'(cnt) + 32'(d[7:4])) % 20));
    mask = 21'((64'd1 << len) - 64'd1);
    cw   = (d[20:0] ^ 21'h15A5A) & mask;
    return {1'b1, len, cw};
  endfunction

  assign {cb_match_i, cb_length_i, cb_data_i} = cb_lookup(ap_cnt_o, ap_data_o);

  typedef struct packed {
    logic        flush;
    logic [5:0]  len;
    logic [63:0] data;
  } beat_t;

  beat_t       sb[$];
  logic [3:0]  pq[$];
  bit          err_model = 1'b0;
  int unsigned nchk = 0;
  int unsigned nerr = 0;
  int          ready_mode = 1;  // 0: stall, 1: always ready, 2: random

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] prefix_data();
    logic [63:0] d = '0;
    foreach (pq[i]) d = {d[59:0], pq[i]};
    return d;
  endfunction

  function automatic logic [63:0] cand_data(input logic [3:0] s);
    logic [63:0] d = prefix_data();
    return {d[59:0], s};
  endfunction

  task automatic model_accept(input logic [3:0] s, input bit push);
    logic [5:0]  cnt;
    logic [63:0] d;
    logic [27:0] cb;
    cnt = 6'(pq.size() + 1);
    d   = cand_data(s);
    cb  = cb_lookup(cnt, d);
    if (cb[27]) begin
      if (push) sb.push_back({1'b0, cb[26:21], 43'b0, cb[20:0]});
      pq.delete();
    end else if (cnt == 6'd12) begin
      if (OVF_EN) begin
        if (push) sb.push_back({1'b1, 6'd12, d});
        err_model = 1'b1;
      end
      pq.delete();
    end else begin
      pq.push_back(s);
    end
  endtask

  task automatic model_flush(input bit push);
    if (pq.size() != 0 && push) sb.push_back({1'b1, 6'(pq.size()), prefix_data()});
    pq.delete();
  endtask

  // Backpressure generator
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      case (ready_mode)
        0:       cw_ready_i = 1'b0;
        1:       cw_ready_i = 1'b1;
        default: cw_ready_i = ($urandom_range(0, 99) < 70);
      endcase
    end
  end

  // Monitor: pops the scoreboard on every accepted beat and checks that a
  // stalled beat holds its contents.
  bit    hold_prev = 1'b0;
  beat_t prev_beat;
  always @(negedge clk_i) begin
    if (rst_i) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", 80'(cw_valid_o), 80'd1);
        chk("hold_stable", 80'({cw_flush_o, cw_length_o, cw_data_o}), 80'(prev_beat));
      end
      if (cw_valid_o && cw_ready_i) begin
        if (sb.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL unexpected_beat: got flush=%0d len=%0d data=%0h expected none at %0t",
                   cw_flush_o, cw_length_o, cw_data_o, $time);
        end else begin
          beat_t e;
          e = sb.pop_front();
          chk("beat_flush", 80'(cw_flush_o), 80'(e.flush));
          chk("beat_len", 80'(cw_length_o), 80'(e.len));
          chk("beat_data", 80'(cw_data_o), 80'(e.data));
        end
      end
      hold_prev = cw_valid_o && !cw_ready_i;
      prev_beat = {cw_flush_o, cw_length_o, cw_data_o};
    end
  end

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(negedge clk_i);
      chk("err_o", 80'(err_o), 80'(err_model));
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic drive_sym(input logic [3:0] s, input bit push);
    int unsigned waited = 0;
    bit          done = 1'b0;
    sym_i = s;
    sym_valid_i = 1'b1;
    while (!done) begin
      @(negedge clk_i);
      chk("err_o", 80'(err_o), 80'(err_model));
      if (sym_ready_o) begin
        chk("cand_cnt", 80'(ap_cnt_o), 80'(pq.size() + 1));
        chk("cand_data", 80'(ap_data_o), 80'(cand_data(s)));
        model_accept(s, push);
        done = 1'b1;
      end else if (++waited > 200) begin
        nchk++;
        nerr++;
        $display("FAIL sym_accept_timeout: got sym_ready_o=0 for 200 cycles expected accept at %0t", $time);
        done = 1'b1;
      end
      @(posedge clk_i);
      #1;
    end
    sym_valid_i = 1'b0;
  endtask

  task automatic do_flush(input int unsigned hold, input bit push);
    flush_i = 1'b1;
    sym_i = 4'($urandom_range(0, 15));
    sym_valid_i = 1'($urandom_range(0, 1));
    for (int unsigned k = 0; k < hold; k++) begin
      @(negedge clk_i);
      chk("flush_blocks_sym", 80'(sym_ready_o), 80'd0);
      if (k == 0) model_flush(push);
      @(posedge clk_i);
      #1;
    end
    flush_i = 1'b0;
    sym_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    sym_valid_i = 1'b0;
    flush_i = 1'b0;
    sym_i = 4'h0;
    rst_i = 1'b1;
    #1;
    chk("rst_cw_valid", 80'(cw_valid_o), 80'd0);
    chk("rst_cw_flush", 80'(cw_flush_o), 80'd0);
    chk("rst_cw_length", 80'(cw_length_o), 80'd0);
    chk("rst_cw_data", 80'(cw_data_o), 80'd0);
    chk("rst_err", 80'(err_o), 80'd0);
    chk("rst_ap_cnt", 80'(ap_cnt_o), 80'd1);
    chk("rst_ap_data", 80'(ap_data_o), 80'd0);
    sb.delete();
    pq.delete();
    err_model = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    #2;
    do_reset();
    idle(1);

    // Single escape symbol
    sb.push_back({1'b0, 6'd9, 64'h1EC});
    drive_sym(4'hF, 1'b0);
    idle(2);

    // Backpressure: stalled beat blocks input, next symbol is not lost
    ready_mode = 0;
    idle(1);
    sb.push_back({1'b0, 6'd9, 64'h1EC});
    drive_sym(4'hF, 1'b0);
    fork
      drive_sym(4'h1, 1'b1);
      begin
        repeat (4) begin
          @(negedge clk_i);
          chk("bp_sym_ready", 80'(sym_ready_o), 80'd0);
        end
        @(posedge clk_i);
        #1;
        ready_mode = 1;
      end
    join
    sym_i = 4'hF;
    #1;
    chk("cand_cnt_1F", 80'(ap_cnt_o), 80'd2);
    chk("cand_data_1F", 80'(ap_data_o), 80'h1F);
    sb.push_back({1'b0, 6'd12, 64'hFF8});
    drive_sym(4'hF, 1'b0);

    // 2,1,F
    sb.push_back({1'b0, 6'd16, 64'hFFFE});
    drive_sym(4'h2, 1'b0);
    drive_sym(4'h1, 1'b0);
    drive_sym(4'hF, 1'b0);

    // Nine zeros then F
    sb.push_back({1'b0, 6'd12, 64'hFFB});
    repeat (9) drive_sym(4'h0, 1'b0);
    drive_sym(4'hF, 1'b0);

    // Flush of 0,0,0 (flush held), then flush of an empty prefix
    sb.push_back({1'b1, 6'd3, 64'h0});
    repeat (3) drive_sym(4'h0, 1'b0);
    do_flush(3, 1'b0);
    do_flush(2, 1'b0);
    idle(2);

    // Overflow: twelve zeros, no escape
    if (OVF_EN) sb.push_back({1'b1, 6'd12, 64'h0});
    repeat (12) drive_sym(4'h0, 1'b0);
    idle(3);
    chk("ovf_err", 80'(err_o), 80'(OVF_EN));
    sym_i = 4'h0;
    #1;
    chk("ovf_prefix_empty", 80'(ap_cnt_o), 80'd1);

    // Reset with a pending beat, then with a partial prefix
    ready_mode = 0;
    idle(1);
    drive_sym(4'hF, 1'b1);
    idle(1);
    do_reset();
    ready_mode = 1;
    idle(3);
    drive_sym(4'h7, 1'b1);
    drive_sym(4'h7, 1'b1);
    do_reset();
    sb.push_back({1'b0, 6'd9, 64'h1EC});
    drive_sym(4'hF, 1'b0);
    idle(2);

    // Randomized traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      int unsigned op;
      if (i % 50 == 0) ready_mode = ($urandom_range(0, 1) == 0) ? 1 : 2;
      op = $urandom_range(0, 99);
      if (op < 80) begin
        logic [3:0] s;
        s = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 15));
        drive_sym(s, 1'b1);
      end else if (op < 88) begin
        do_flush($urandom_range(1, 3), 1'b1);
      end else begin
        idle($urandom_range(1, 2));
      end
    end

    // Drain
    ready_mode = 1;
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk_i);
    chk("sb_drained", 80'(sb.size()), 80'd0);
    idle(2);
    chk("final_cw_valid", 80'(cw_valid_o), 80'd0);
    chk("final_err", 80'(err_o), 80'(err_model));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
